// File: rtl/btd_seq.sv
// Sequential approximate divider: rounds NAB LSBs off both operands, then runs a
// one-bit-per-clock restoring division. Define BTD_ROUND_Q_EN to round the quotient.
module btd_seq #(
  parameter int BWOP = 32,
  parameter int NAB  = 1
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [BWOP-1:0] i_a,
  input  logic [BWOP-1:0] i_b,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [BWOP-1:0] o_q,
  output logic [BWOP-1:0] o_r,
  output logic            o_dz
);

  localparam int W  = BWOP - NAB;
  localparam int CW = $clog2(W + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [BWOP:0] ONE  = 1;
  localparam logic [BWOP:0] HALF = (ONE << NAB) >> 1;
  localparam logic [BWOP:0] SAT  = (ONE << W) - ONE;
  localparam logic [W-1:0]  QMAX = '1;

  // Round-half-up on the dropped LSBs; results that no longer fit W bits saturate.
  function automatic logic [W-1:0] reduce(input logic [BWOP-1:0] x);
    logic [BWOP:0] shr;
    shr = ({1'b0, x} + HALF) >> NAB;
    if (shr > SAT) begin
      return QMAX;
    end else begin
      return W'(shr);
    end
  endfunction

  logic [1:0]    state_reg;
  logic [W-1:0]  a_reg;
  logic [W-1:0]  b_reg;
  logic [W-1:0]  rem_reg;
  logic [CW-1:0] cnt_reg;

  logic [W-1:0]  a_red;
  logic [W-1:0]  b_red;
  logic [W:0]    rem_shift;
  logic          q_bit;
  logic [W-1:0]  rem_next;
  logic [W-1:0]  a_next;
  logic [W-1:0]  q_final;

  assign a_red   = reduce(i_a);
  assign b_red   = reduce(i_b);
  assign o_ready = (state_reg == IDLE);

  // The dividend register doubles as the quotient register: dividend bits leave at
  // the top while quotient bits enter at the bottom.
  always_comb begin
    rem_shift = {rem_reg, a_reg[W-1]};
    q_bit     = (rem_shift >= {1'b0, b_reg});
    rem_next  = q_bit ? W'(rem_shift - {1'b0, b_reg}) : rem_shift[W-1:0];
    a_next    = W'({a_reg, q_bit});
`ifdef BTD_ROUND_Q_EN
    q_final   = a_next;
    if (({rem_next, 1'b0} >= {1'b0, b_reg}) && (a_next != QMAX)) begin
      q_final = a_next + W'(1);
    end
`else
    q_final   = a_next;
`endif
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      rem_reg   <= '0;
      cnt_reg   <= '0;
      o_valid   <= 1'b0;
      o_q       <= '0;
      o_r       <= '0;
      o_dz      <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (i_valid) begin
            a_reg     <= a_red;
            b_reg     <= b_red;
            rem_reg   <= '0;
            cnt_reg   <= CW'(W);
            state_reg <= (b_red == '0) ? DONE : CALC;
          end
        end
        CALC: begin
          a_reg   <= a_next;
          rem_reg <= rem_next;
          cnt_reg <= cnt_reg - CW'(1);
          if (cnt_reg == CW'(1)) begin
            o_q       <= BWOP'(q_final);
            o_r       <= BWOP'(rem_next) << NAB;
            o_dz      <= 1'b0;
            o_valid   <= 1'b1;
            state_reg <= DONE;
          end
        end
        DONE: begin
          // Entering DONE with o_valid low means the divide-by-zero path: publish it now.
          if (!o_valid) begin
            o_q     <= BWOP'(QMAX);
            o_r     <= BWOP'(a_reg) << NAB;
            o_dz    <= 1'b1;
            o_valid <= 1'b1;
          end else if (i_ready) begin
            o_valid   <= 1'b0;
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_btd_seq.sv
// Bench for btd_seq: directed vector table, reset/backpressure/back-to-back sequences,
// and randomized operations checked against an arithmetic reference model.
module tb_btd_seq;

  logic       clk;
  logic       rst_n;
  logic       sel;
  logic       drv_valid;
  logic       i_ready;
  logic [7:0] a;
  logic [7:0] b;

  logic       valid1, valid0;
  logic       ready1, ready0, ov1, ov0, dz1, dz0;
  logic [7:0] q1, q0, r1, r0;
  logic       m_ready, m_valid, m_dz;
  logic [7:0] m_q, m_r;

  int n_checks = 0;
  int n_fail   = 0;

  assign valid1  = drv_valid && sel;
  assign valid0  = drv_valid && !sel;
  assign m_ready = sel ? ready1 : ready0;
  assign m_valid = sel ? ov1 : ov0;
  assign m_q     = sel ? q1 : q0;
  assign m_r     = sel ? r1 : r0;
  assign m_dz    = sel ? dz1 : dz0;

  btd_seq #(.BWOP(8), .NAB(1)) u_dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid1), .o_ready(ready1),
    .i_a(a), .i_b(b), .o_valid(ov1), .i_ready(i_ready),
    .o_q(q1), .o_r(r1), .o_dz(dz1)
  );

  btd_seq #(.BWOP(8), .NAB(0)) u_dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid0), .o_ready(ready0),
    .i_a(a), .i_b(b), .o_valid(ov0), .i_ready(i_ready),
    .o_q(q0), .o_r(r0), .o_dz(dz0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the rounded operands.
  function automatic void model(input int nab, input int xa, input int xb,
                                output int q, output int r, output int dz, output int lat);
    int w, mx, half, ar, br, rr;
    w    = 8 - nab;
    mx   = (1 << w) - 1;
    half = (nab > 0) ? (1 << (nab - 1)) : 0;
    ar   = (xa + half) >> nab;
    br   = (xb + half) >> nab;
    if (ar > mx) ar = mx;
    if (br > mx) br = mx;
    if (br == 0) begin
      q = mx; r = ar << nab; dz = 1; lat = 1;
    end else begin
      q  = ar / br;
      rr = ar % br;
`ifdef BTD_ROUND_Q_EN
      if ((2 * rr >= br) && (q < mx)) q = q + 1;
`endif
      r = rr << nab; dz = 0; lat = w;
    end
  endfunction

  task automatic do_op(input logic s, input logic [7:0] ta, input logic [7:0] tb_v,
                       output logic [7:0] gq, output logic [7:0] gr, output logic gdz,
                       output int lat);
    int wt;
    @(negedge clk);
    sel = s;
    #1;
    wt = 0;
    while (!m_ready && wt < 50) begin
      @(negedge clk);
      wt++;
    end
    if (!m_ready) chk("ready_wait", 0, 1);
    a = ta;
    b = tb_v;
    drv_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    drv_valid = 1'b0;
    a = 8'($urandom);
    b = 8'($urandom);
    lat = 0;
    while (!m_valid && lat < 40) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    if (!m_valid) chk("result_timeout", 0, 1);
    gq  = m_q;
    gr  = m_r;
    gdz = m_dz;
    i_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    i_ready = 1'b0;
    chk("valid_drop", 32'(m_valid), 0);
    chk("ready_return", 32'(m_ready), 1);
    $display("op nab=%0d a=%0d b=%0d -> q=%0d r=%0d dz=%0d lat=%0d",
             s ? 1 : 0, ta, tb_v, gq, gr, gdz, lat);
  endtask

  typedef struct {
    logic       s;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] q;
    logic [7:0] qr;
    logic [7:0] r;
    logic       dz;
    int         lat;
  } vec_t;

  vec_t vecs[11];

  initial begin
    logic [7:0] gq, gr, eq;
    logic       gdz;
    int         lat, mq, mr, mdz, mlat, vcount, idx, nres;
    int         acc_cyc[3];
    logic [7:0] pa[3];
    logic [7:0] pb[3];
    logic [7:0] res_q[3];
    logic [7:0] res_r[3];

    vecs[0]  = '{1'b1, 8'd100, 8'd7,   8'd12,  8'd13,  8'd4,  1'b0, 7};
    vecs[1]  = '{1'b1, 8'd255, 8'd2,   8'd127, 8'd127, 8'd0,  1'b0, 7};
    vecs[2]  = '{1'b0, 8'd200, 8'd3,   8'd66,  8'd67,  8'd2,  1'b0, 8};
    vecs[3]  = '{1'b1, 8'd9,   8'd0,   8'd127, 8'd127, 8'd10, 1'b1, 1};
    vecs[4]  = '{1'b1, 8'd9,   8'd1,   8'd5,   8'd5,   8'd0,  1'b0, 7};
    vecs[5]  = '{1'b1, 8'd0,   8'd5,   8'd0,   8'd0,   8'd0,  1'b0, 7};
    vecs[6]  = '{1'b0, 8'd0,   8'd0,   8'd255, 8'd255, 8'd0,  1'b1, 1};
    vecs[7]  = '{1'b1, 8'd254, 8'd254, 8'd1,   8'd1,   8'd0,  1'b0, 7};
    vecs[8]  = '{1'b1, 8'd3,   8'd255, 8'd0,   8'd0,   8'd4,  1'b0, 7};
    vecs[9]  = '{1'b0, 8'd255, 8'd16,  8'd15,  8'd16,  8'd15, 1'b0, 8};
    vecs[10] = '{1'b1, 8'd255, 8'd3,   8'd63,  8'd64,  8'd2,  1'b0, 7};

    rst_n = 1'b0; sel = 1'b1; drv_valid = 1'b0; i_ready = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(ready1), 1);
    chk("rst_valid", 32'(ov1), 0);
    chk("rst_q", 32'(q1), 0);
    chk("rst_r", 32'(r1), 0);
    chk("rst_dz", 32'(dz1), 0);
    chk("rst_ready_nab0", 32'(ready0), 1);
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++) begin
`ifdef BTD_ROUND_Q_EN
      eq = vecs[i].qr;
`else
      eq = vecs[i].q;
`endif
      do_op(vecs[i].s, vecs[i].a, vecs[i].b, gq, gr, gdz, lat);
      chk($sformatf("vec%0d_q", i), 32'(gq), 32'(eq));
      chk($sformatf("vec%0d_r", i), 32'(gr), 32'(vecs[i].r));
      chk($sformatf("vec%0d_dz", i), 32'(gdz), 32'(vecs[i].dz));
      chk($sformatf("vec%0d_lat", i), lat, vecs[i].lat);
    end

    // Reset in the middle of a calculation.
    @(negedge clk);
    sel = 1'b1; a = 8'd100; b = 8'd7; drv_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    drv_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("midcalc_ready_busy", 32'(ready1), 0);
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(ov1), 0);
    chk("midrst_ready", 32'(ready1), 1);
    @(negedge clk);
    rst_n = 1'b1;
    i_ready = 1'b1;
    vcount = 0;
    repeat (15) begin
      @(negedge clk);
      if (ov1) vcount++;
    end
    i_ready = 1'b0;
    chk("midrst_no_result", vcount, 0);
    $display("reset mid-calc sequence done");

    // Backpressure: result held while the consumer stalls.
    model(1, 100, 7, mq, mr, mdz, mlat);
    @(negedge clk);
    sel = 1'b1; a = 8'd100; b = 8'd7; drv_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    drv_valid = 1'b0;
    lat = 0;
    while (!ov1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("bp_valid_seen", 32'(ov1), 1);
    for (int k = 0; k < 5; k++) begin
      drv_valid = ~drv_valid;
      a = 8'($urandom);
      b = 8'($urandom);
      @(negedge clk);
      chk("bp_hold_valid", 32'(ov1), 1);
      chk("bp_hold_q", 32'(q1), mq);
      chk("bp_hold_r", 32'(r1), mr);
      chk("bp_hold_ready", 32'(ready1), 0);
    end
    drv_valid = 1'b0;
    i_ready = 1'b1;
    vcount = 0;
    repeat (12) begin
      @(negedge clk);
      if (ov1) vcount++;
    end
    i_ready = 1'b0;
    chk("bp_consumed_once", vcount, 0);
    $display("backpressure sequence done q=%0d r=%0d", mq, mr);

    // Back-to-back with i_valid held high.
    pa[0] = 8'd100; pb[0] = 8'd7;
    pa[1] = 8'd255; pb[1] = 8'd3;
    pa[2] = 8'd9;   pb[2] = 8'd1;
    idx = 0; nres = 0; i_ready = 1'b1; sel = 1'b1;
    for (int cyc = 0; cyc < 200 && nres < 3; cyc++) begin
      @(negedge clk);
      if (ov1) begin
        res_q[nres] = q1;
        res_r[nres] = r1;
        nres++;
      end
      if (idx < 3) begin
        a = pa[idx]; b = pb[idx]; drv_valid = 1'b1;
        if (ready1) begin
          acc_cyc[idx] = cyc;
          idx++;
        end
      end else begin
        drv_valid = 1'b0;
      end
    end
    drv_valid = 1'b0;
    i_ready = 1'b0;
    chk("b2b_results", nres, 3);
    chk("b2b_accepts", idx, 3);
    if (nres == 3 && idx == 3) begin
      for (int k = 0; k < 3; k++) begin
        model(1, int'(pa[k]), int'(pb[k]), mq, mr, mdz, mlat);
        chk($sformatf("b2b%0d_q", k), 32'(res_q[k]), mq);
        chk($sformatf("b2b%0d_r", k), 32'(res_r[k]), mr);
        $display("b2b op %0d accepted at cycle %0d q=%0d r=%0d", k, acc_cyc[k], res_q[k], res_r[k]);
      end
      chk("b2b_spacing01", acc_cyc[1] - acc_cyc[0], 9);
      chk("b2b_spacing12", acc_cyc[2] - acc_cyc[1], 9);
    end

    // Randomized operations against the model.
    for (int i = 0; i < 40; i++) begin
      logic       rs;
      logic [7:0] ra, rb;
      rs = 1'($urandom_range(0, 1));
      ra = 8'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom);
      model(rs ? 1 : 0, int'(ra), int'(rb), mq, mr, mdz, mlat);
      do_op(rs, ra, rb, gq, gr, gdz, lat);
      chk("rnd_q", 32'(gq), mq);
      chk("rnd_r", 32'(gr), mr);
      chk("rnd_dz", 32'(gdz), mdz);
      chk("rnd_lat", lat, mlat);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
